// File: rtl/csk_adder_pipe.sv
// rtl/csk_adder_pipe.sv - registered carry-skip adder with per-group skip flags
// One pipeline stage: a combinational carry-skip core feeding the output registers.
module csk_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [WIDTH/BLOCK-1:0] skip
);

  localparam int NGROUP = WIDTH / BLOCK;

  logic [WIDTH-1:0]  w_sum;
  logic [NGROUP-1:0] w_skip;
  logic              w_carry;
  logic              w_gc;
  logic              w_rc;
  logic              w_sel;
  logic              w_p;
  logic              w_cmsb;

  // Ripple within each group; the group carry-out is muxed between the
  // ripple result and the group carry-in when every bit propagates.
  always_comb begin
    w_sum   = '0;
    w_skip  = '0;
    w_carry = cin;
    w_gc    = 1'b0;
    w_rc    = 1'b0;
    w_sel   = 1'b0;
    w_p     = 1'b0;
    w_cmsb  = 1'b0;
    for (int g = 0; g < NGROUP; g++) begin
      w_gc  = w_carry;
      w_rc  = w_gc;
      w_sel = 1'b1;
      for (int k = 0; k < BLOCK; k++) begin
        w_p = a[g*BLOCK+k] ^ b[g*BLOCK+k];
        w_sum[g*BLOCK+k] = w_p ^ w_rc;
        if (g*BLOCK+k == WIDTH-1) w_cmsb = w_rc;
        w_rc  = (a[g*BLOCK+k] & b[g*BLOCK+k]) | (w_p & w_rc);
        w_sel = w_sel & w_p;
      end
      w_skip[g] = w_sel;
      w_carry   = w_sel ? w_gc : w_rc;
    end
  end

  logic                   r_valid;
  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;
  logic                   r_ovf;
  logic [NGROUP-1:0]      r_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_skip  <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry;
        r_ovf  <= w_cmsb ^ w_carry;
        r_skip <= w_skip;
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign skip      = r_skip;

endmodule

// File: tb/tb_csk_adder_pipe.sv
// tb/tb_csk_adder_pipe.sv - self-checking bench for csk_adder_pipe
module tb_csk_adder_pipe;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NG    = WIDTH / BLOCK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;
  logic [NG-1:0]    skip;

  int n_checks = 0;
  int n_errors = 0;

  csk_adder_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf), .skip(skip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] e_sum;
    logic        e_cout, e_ovf;
    logic [3:0]  e_skip;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic);
    @(negedge clk);
    in_valid = v; a = ia; b = ib; cin = ic;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic and signed-overflow rule.
  task automatic ref_add(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic,
                         output logic [WIDTH-1:0] rs, output logic rc, output logic ro,
                         output logic [NG-1:0] rk);
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] x;
    full = {1'b0, ia} + {1'b0, ib} + {{WIDTH{1'b0}}, ic};
    rs = full[WIDTH-1:0];
    rc = full[WIDTH];
    ro = (ia[WIDTH-1] == ib[WIDTH-1]) && (rs[WIDTH-1] != ia[WIDTH-1]);
    x = ia ^ ib;
    for (int g = 0; g < NG; g++) rk[g] = &x[g*BLOCK +: BLOCK];
  endtask

  initial begin
    logic [WIDTH-1:0] rs, ra, rb, held;
    logic rc, ro, rci;
    logic [NG-1:0] rk;

    vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_sum", {16'b0, sum}, 0);
    check("rst_flags", {29'b0, cout, ovf, |skip}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors, issued back-to-back
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      step();
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
      check($sformatf("vec%0d_sum", i), {16'b0, sum}, {16'b0, vecs[i].e_sum});
      check($sformatf("vec%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].e_cout});
      check($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].e_ovf});
      check($sformatf("vec%0d_skip", i), {28'b0, skip}, {28'b0, vecs[i].e_skip});
    end

    // Hold: dropping in_valid keeps the last result
    drive(1'b1, 16'h1234, 16'h0001, 1'b0);
    step();
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    step();
    check("hold_valid", {31'b0, out_valid}, 0);
    check("hold_sum", {16'b0, sum}, 32'h1235);
    check("hold_flags", {29'b0, cout, ovf, |skip}, 0);

    // Asynchronous reset between edges discards the held result
    drive(1'b1, 16'h1234, 16'h0001, 1'b0);
    step();
    check("pre_rst_sum", {16'b0, sum}, 32'h1235);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 0);
    check("async_rst_sum", {16'b0, sum}, 0);
    step();
    check("rst_hold_valid", {31'b0, out_valid}, 0);
    check("rst_hold_sum", {16'b0, sum}, 0);
    drive(1'b1, 16'h00FF, 16'hFF00, 1'b1);
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {31'b0, out_valid}, 1);
    check("post_rst_cout", {31'b0, cout}, 1);
    check("post_rst_skip", {28'b0, skip}, 32'hF);

    // Randomised full-throughput stream
    held = sum;
    for (int n = 0; n < 10000; n++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rci = 1'($urandom);
      drive(1'b1, ra, rb, rci);
      step();
      ref_add(ra, rb, rci, rs, rc, ro, rk);
      check("rnd_valid", {31'b0, out_valid}, 1);
      check("rnd_sum", {16'b0, sum}, {16'b0, rs});
      check("rnd_cout", {31'b0, cout}, {31'b0, rc});
      check("rnd_ovf", {31'b0, ovf}, {31'b0, ro});
      check("rnd_skip", {28'b0, skip}, {28'b0, rk});
      held = rs;
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("final_hold_valid", {31'b0, out_valid}, 0);
    check("final_hold_sum", {16'b0, sum}, {16'b0, held});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
